// File: rtl/mxrv_id_ctrl_pkg.sv
// Shared definitions for the decode-stage issue controller: opcodes, widths,
// the buffered {pc,inst} payload and the controller state encoding.
package mxrv_id_ctrl_pkg;

  localparam int unsigned PORT_WORD_WIDTH = 32;
  localparam int unsigned REG_ADDR_WIDTH  = 5;
  localparam int unsigned OPCODE_WIDTH    = 7;
  localparam int unsigned STALL_CNT_WIDTH = 16;

  localparam logic [OPCODE_WIDTH-1:0] INST_LUI      = 7'b0110111;
  localparam logic [OPCODE_WIDTH-1:0] INST_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_WIDTH-1:0] INST_JAL      = 7'b1101111;
  localparam logic [OPCODE_WIDTH-1:0] INST_JALR     = 7'b1100111;
  localparam logic [OPCODE_WIDTH-1:0] INST_TYPE_R_M = 7'b0110011;
  localparam logic [OPCODE_WIDTH-1:0] INST_TYPE_S   = 7'b0100011;
  localparam logic [OPCODE_WIDTH-1:0] INST_TYPE_B   = 7'b1100011;

  localparam logic [PORT_WORD_WIDTH-1:0] INST_NOP = 32'h00000013;

  typedef struct packed {
    logic [PORT_WORD_WIDTH-1:0] pc;
    logic [PORT_WORD_WIDTH-1:0] inst;
  } id_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(id_entry_t);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } id_state_e;

  // Upper-immediate and jal forms carry immediate bits where rs1 would sit.
  function automatic logic uses_rs1(input logic [OPCODE_WIDTH-1:0] op);
    logic r;
    case (op)
      INST_LUI, INST_AUIPC, INST_JAL: r = 1'b0;
      INST_JALR:                      r = 1'b1;
      default:                        r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [OPCODE_WIDTH-1:0] op);
    logic r;
    case (op)
      INST_TYPE_R_M, INST_TYPE_S, INST_TYPE_B: r = 1'b1;
      default:                                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mxrv_sync_fifo.sv
// Registered synchronous FIFO (no fall-through) with a synchronous clear that
// overrides push and pop. DEPTH must be a power of two so pointers wrap freely.
module mxrv_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pointer and occupancy update; clear wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: reads are only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mxrv_id_ctrl.sv
// Decode-stage issue controller: buffers fetched {pc,inst}, presents the head
// to the decoder, holds issue on load-use hazards and discards words on flush.
module mxrv_id_ctrl
  import mxrv_id_ctrl_pkg::*;
#(
  parameter int unsigned                FIFO_DEPTH = 2,
  parameter logic [PORT_WORD_WIDTH-1:0] NOP_INST   = INST_NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid_i,
  output logic                       if_ready_o,
  input  logic [PORT_WORD_WIDTH-1:0] if_inst_i,
  input  logic [PORT_WORD_WIDTH-1:0] if_pc_i,
  output logic [PORT_WORD_WIDTH-1:0] inst_data_o,
  output logic [PORT_WORD_WIDTH-1:0] id_pc_o,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0]  dec_rs2_i,
  input  logic                       ex_load_pend_i,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_load_rd_i,
  output logic                       id_valid_o,
  input  logic                       ex_ready_i,
  input  logic                       flush_i,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  id_state_e                  state_q, state_d;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  id_entry_t                  wr_entry, head;
  logic                       fifo_empty, fifo_full;
  logic                       push, pop;
  logic [OPCODE_WIDTH-1:0]    opcode;
  logic                       rs1_hit, rs2_hit, hazard;

  assign wr_entry = '{pc: if_pc_i, inst: if_inst_i};

  mxrv_sync_fifo #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign if_ready_o  = ~fifo_full & ~rst;
  assign push        = if_valid_i & if_ready_o & ~flush_i;
  assign pop         = id_valid_o & ex_ready_i;
  assign inst_data_o = fifo_empty ? NOP_INST : head.inst;
  assign id_pc_o     = fifo_empty ? '0 : head.pc;
  assign stall_cnt_o = stall_cnt_q;

  // Load-use detection against the register fields the decoder reports back.
  assign opcode  = inst_data_o[OPCODE_WIDTH-1:0];
  assign rs1_hit = uses_rs1(opcode) & (ex_load_rd_i == dec_rs1_i);
  assign rs2_hit = uses_rs2(opcode) & (ex_load_rd_i == dec_rs2_i);
  assign hazard  = ex_load_pend_i & (ex_load_rd_i != '0) & (rs1_hit | rs2_hit);

  always_comb begin
    state_d     = state_q;
    id_valid_o  = 1'b0;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_RUN: begin
        if (flush_i)                   state_d = ST_FLUSH;
        else if (~fifo_empty & hazard) state_d = ST_STALL;
      end
      ST_STALL: begin
        if (flush_i)      state_d = ST_FLUSH;
        else if (~hazard) state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    id_valid_o = ~fifo_empty & (state_q == ST_RUN) & ~hazard & ~flush_i;

    if ((state_q == ST_STALL) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
